// File: rtl/div_pkg.sv
// Shared definitions for the RV32M divide/remainder unit.
// Holds the funct3/funct7 encodings and the FSM state type.
package div_pkg;

    localparam int DATA_W = 32;

    localparam logic [2:0] INST_DIV  = 3'b100;
    localparam logic [2:0] INST_DIVU = 3'b101;
    localparam logic [2:0] INST_REM  = 3'b110;
    localparam logic [2:0] INST_REMU = 3'b111;

    localparam logic [6:0] FUNCT7_M = 7'b0000001;

    typedef enum logic [1:0] {
        DIV_IDLE  = 2'd0,
        DIV_START = 2'd1,
        DIV_CALC  = 2'd2,
        DIV_END   = 2'd3
    } div_state_e;

    function automatic logic is_m_ext(input logic [6:0] funct7);
        return funct7 == FUNCT7_M;
    endfunction

endpackage

// File: rtl/div_if.sv
// Request/response bundle between ex and the divider.
// master = ex side, slave = divider side.
interface div_if import div_pkg::*; ();

    logic              start_i;
    logic              flush_i;
    logic [2:0]        op_i;
    logic [DATA_W-1:0] dividend_i;
    logic [DATA_W-1:0] divisor_i;
    logic [4:0]        reg_waddr_i;
    logic [DATA_W-1:0] result_o;
    logic              ready_o;
    logic              busy_o;
    logic [4:0]        reg_waddr_o;

    modport master (
        output start_i, flush_i, op_i, dividend_i, divisor_i, reg_waddr_i,
        input  result_o, ready_o, busy_o, reg_waddr_o
    );

    modport slave (
        input  start_i, flush_i, op_i, dividend_i, divisor_i, reg_waddr_i,
        output result_o, ready_o, busy_o, reg_waddr_o
    );

endinterface

// File: rtl/div.sv
// Iterative restoring divider for DIV/DIVU/REM/REMU: one quotient bit per cycle,
// with divide-by-zero and signed overflow resolved directly in START.
module div import div_pkg::*; (
    input  logic clk,
    input  logic rst,
    div_if.slave bus
);

    div_state_e        state, state_nxt;
    logic [2:0]        op_r;
    logic [DATA_W-1:0] dvd_r, dvs_r, quot, rem;
    logic [4:0]        rd_r, cnt;
    logic              neg_q, neg_r, special;

    logic              signed_op, is_rem, div_by_zero, overflow, take;
    logic [DATA_W:0]   trial;
    logic [DATA_W-1:0] diff, q_fin, r_fin;

    function automatic logic [DATA_W-1:0] negate(input logic [DATA_W-1:0] v);
        return ~v + 1'b1;
    endfunction

    function automatic logic [DATA_W-1:0] abs_val(input logic signed [DATA_W-1:0] v);
        return v[DATA_W-1] ? negate(v) : v;
    endfunction

    always_comb begin
        signed_op   = (op_r == INST_DIV) || (op_r == INST_REM);
        is_rem      = (op_r == INST_REM) || (op_r == INST_REMU);
        div_by_zero = (dvs_r == '0);
        overflow    = signed_op && (dvd_r == 32'h8000_0000) && (dvs_r == '1);
        trial       = {rem, dvd_r[cnt]};
        take        = (trial >= {1'b0, dvs_r});
        diff        = trial[DATA_W-1:0] - dvs_r;
        q_fin       = (!special && neg_q) ? negate(quot) : quot;
        r_fin       = (!special && neg_r) ? negate(rem)  : rem;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= DIV_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            DIV_IDLE:  if (bus.start_i && !bus.flush_i) state_nxt = DIV_START;
            DIV_START: if (bus.flush_i)                 state_nxt = DIV_IDLE;
                       else if (div_by_zero || overflow) state_nxt = DIV_END;
                       else                             state_nxt = DIV_CALC;
            DIV_CALC:  if (bus.flush_i)                 state_nxt = DIV_IDLE;
                       else if (cnt == '0)              state_nxt = DIV_END;
            DIV_END:                                    state_nxt = DIV_IDLE;
            default:                                    state_nxt = DIV_IDLE;
        endcase
    end

    always_comb begin
        bus.busy_o = (state != DIV_IDLE);
    end

    // Operand latch: signed operands are replaced by their magnitudes in START.
    always_ff @(posedge clk) begin
        case (state)
            DIV_IDLE: if (bus.start_i && !bus.flush_i) begin
                op_r  <= bus.op_i;
                dvd_r <= bus.dividend_i;
                dvs_r <= bus.divisor_i;
                rd_r  <= bus.reg_waddr_i;
            end
            DIV_START: begin
                special <= div_by_zero || overflow;
                neg_q   <= signed_op && (dvd_r[DATA_W-1] ^ dvs_r[DATA_W-1]);
                neg_r   <= signed_op && dvd_r[DATA_W-1];
                if (signed_op) begin
                    dvd_r <= abs_val(dvd_r);
                    dvs_r <= abs_val(dvs_r);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt             <= '0;
            quot            <= '0;
            rem             <= '0;
            bus.result_o    <= '0;
            bus.ready_o     <= 1'b0;
            bus.reg_waddr_o <= '0;
        end else begin
            bus.ready_o <= 1'b0;
            case (state)
                DIV_START: begin
                    if (div_by_zero) begin
                        quot <= '1;
                        rem  <= dvd_r;
                    end else if (overflow) begin
                        quot <= 32'h8000_0000;
                        rem  <= '0;
                    end else begin
                        rem <= '0;
                        cnt <= 5'd31;
                    end
                end
                DIV_CALC: begin
                    quot[cnt] <= take;
                    rem       <= take ? diff : trial[DATA_W-1:0];
                    if (cnt != '0) cnt <= cnt - 1'b1;
                end
                DIV_END: if (!bus.flush_i) begin
                    bus.result_o    <= is_rem ? r_fin : q_fin;
                    bus.reg_waddr_o <= rd_r;
                    bus.ready_o     <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
